seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000: clk cycles per digit slot (BLANK + SHOW); legal range is 3 or more.
REQ-002 Parameter BLANK_CYC, default 16: inter-digit blanking cycles per slot; legal range is 1 to SCAN_DIV-2.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 sw  input  4: display source select.
REQ-006 freeze  input  1: while high, the frame snapshot is not reloaded.
REQ-007 op  input  6: opcode value to display.
REQ-008 a  input  32: ALU operand A.
REQ-009 b  input  32: ALU operand B.
REQ-010 result  input  32: ALU result.
REQ-011 instr  input  32: current instruction.
REQ-012 led  output  7: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-013 en  output  8: digit anodes, active-low, registered; en[i] shows nibble snap[4i+3:4i].
REQ-014 frame_tick  output  1: one-cycle pulse, registered, marking a snapshot load.

Function
REQ-015 Source mux (combinational) SHALL map sw as follows: 4'b0100 to instr; 4'b0000 to {26'b0,op}; 4'b0001 to a; 4'b0010 to b; 4'b0011 to result; every other code to 32'h0.
REQ-016 The FSM SHALL have two states: BLANK and SHOW. It SHALL hold a 3-bit digit index, a slot cycle counter and a 32-bit snapshot register snap.
REQ-017 BLANK SHALL last exactly BLANK_CYC cycles with en=8'hFF and led=7'h7F.
REQ-018 SHOW SHALL last exactly SCAN_DIV-BLANK_CYC cycles.
  - en has only bit [digit] low.
  - led = decode(snap nibble[digit]).
REQ-019 SHOW to BLANK SHALL increment the digit index; 7 wraps to 0.
REQ-020 Each digit slot period SHALL be exactly SCAN_DIV cycles; each frame SHALL be exactly 8*SCAN_DIV cycles.
REQ-021 Snapshot load condition: first cycle of BLANK with digit==0 and freeze==0.
  - On that edge, snap <= source mux output.
  - frame_tick SHALL be 1 in the following cycle only.
REQ-022 With freeze==1 at the load point, snap SHALL hold its value and frame_tick SHALL stay 0.
  - freeze changes mid-frame SHALL have no effect until the next load point.
REQ-023 sw and operand changes mid-frame SHALL NOT alter the displayed digits until the next load point; no tearing within a frame.
REQ-024 Output registers SHALL lag the FSM state by exactly one cycle, and the lag SHALL be consistent for en and led.
  - en and led SHALL never show a digit change without passing through at least one all-off (8'hFF) cycle.
REQ-025 Decode (hex digit to led) SHALL be: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.

Reset
REQ-026 While rst=1 at an edge, the block SHALL set:
  - state BLANK, digit 0, counter 0;
  - snap 32'h0;
  - en 8'hFF, led 7'h7F, frame_tick 0.
REQ-027 The first cycle after rst falls SHALL be a load point, subject to freeze.
REQ-028 rst asserted mid-SHOW SHALL blank en on the next edge and restart the frame at digit 0; no partial slot completes.

Verification
REQ-029 The bench SHALL run with SCAN_DIV=8 and BLANK_CYC=2, and SHALL cover the scenarios REQ-030 to REQ-035.
REQ-030 Reset scan: sw=0011, result=32'h76543210, freeze=0, release rst.
  - frame_tick SHALL be high for 1 cycle.
  - Digit 0 SHALL show led=7'h40 with en=8'hFE for 6 cycles after 2 blank cycles.
  - Digit 1 SHALL show 7'h79 with en=8'hFD.
  - The sequence SHALL continue through digit 7, which shows 7'h78.
REQ-031 Source codes: sw=0000 with op=6'h23 SHALL give digit0=3 (7'h30), digit1=2 (7'h24), digits2-7=0.
  - sw=1111 SHALL give all digits 7'h40.
REQ-032 Tearing: change sw from 0001 (a=32'hFFFFFFFF) to 0010 (b=0) during digit 3.
  - Digits 4-7 SHALL still show F (7'h0E).
  - The next frame SHALL show 0.
REQ-033 Freeze: freeze=1 before the load point, then change a.
  - frame_tick SHALL stay 0 and the old value SHALL persist.
  - After freeze=0, the new value SHALL appear on the following frame.
REQ-034 Timing: measure the en falling-edge spacing.
  - Spacing SHALL be exactly 8 cycles per digit.
  - Spacing SHALL be 64 cycles between frame_tick pulses.
  - en SHALL be 8'hFF for exactly 2 cycles between digits.
REQ-035 Reset mid-operation: assert rst during SHOW of digit 5 for 1 cycle.
  - en=8'hFF and led=7'h7F SHALL hold on the next edge.
  - snap SHALL be 0, and the scan SHALL restart at digit 0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit multiplexed seven-segment scanner with
// per-frame snapshot of a selected CPU value.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   sw              - display source select
//   freeze          - hold the current snapshot at the frame load point
//   op, a, b,
//   result, instr   - candidate display sources
//   led             - segments {g,f,e,d,c,b,a}, active-low, registered
//   en              - digit anodes, active-low, registered
//   frame_tick      - one-cycle pulse after each snapshot load
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sw,
    input  logic        freeze,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] result,
    input  logic [31:0] instr,
    output logic [6:0]  led,
    output logic [7:0]  en,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);

    typedef enum logic {
        BLANK,
        SHOW
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    digit_q, digit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    en_q, en_d;
    logic [6:0]    led_q, led_d;
    logic          tick_q;
    logic          load;
    logic [31:0]   src;
    logic [3:0]    nib;

    function automatic logic [6:0] seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        case (sw)
            4'b0100: src = instr;
            4'b0000: src = {26'b0, op};
            4'b0001: src = a;
            4'b0010: src = b;
            4'b0011: src = result;
            default: src = 32'h0;
        endcase
    end

    assign nib = snap_q[{digit_q, 2'b00} +: 4];

    // Slot counter runs 0..SCAN_DIV-1 across BLANK then SHOW, so the
    // slot period is fixed regardless of the blank/show split.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = cnt_q + 1'b1;
        snap_d  = snap_q;
        load    = 1'b0;
        en_d    = 8'hFF;
        led_d   = 7'h7F;
        case (state_q)
            BLANK: begin
                load = (cnt_q == '0) && (digit_q == 3'd0) && !freeze;
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                en_d  = ~(8'h01 << digit_q);
                led_d = seg7(nib);
                if (cnt_q == SLOT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = digit_q + 3'd1;
                end
            end
            default: state_d = BLANK;
        endcase
        if (load) begin
            snap_d = src;
        end
    end

    // Outputs are registered from the current state, giving a fixed
    // one-cycle lag shared by en and led.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            digit_q <= 3'd0;
            cnt_q   <= '0;
            snap_q  <= 32'h0;
            en_q    <= 8'hFF;
            led_q   <= 7'h7F;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            en_q    <= en_d;
            led_q   <= led_d;
            tick_q  <= load;
        end
    end

    assign en         = en_q;
    assign led        = led_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with a
// time-based reference model of frames, slots and snapshots.
module tb_seg_scan_ctrl;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 8 * SD;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [3:0]  sw     = 4'b0011;
    logic        freeze = 1'b0;
    logic [5:0]  op     = 6'h0;
    logic [31:0] a      = 32'h0;
    logic [31:0] b      = 32'h0;
    logic [31:0] result = 32'h76543210;
    logic [31:0] instr  = 32'h0;
    logic [6:0]  led;
    logic [7:0]  en;
    logic        frame_tick;

    seg_scan_ctrl #(
        .SCAN_DIV (SD),
        .BLANK_CYC(BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .freeze    (freeze),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .instr     (instr),
        .led       (led),
        .en        (en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] en;
        logic [6:0] led;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] seg_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int errors = 0;
    int checks = 0;
    int n_pop  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [3:0] s);
        case (s)
            4'b0100: return instr;
            4'b0000: return {26'b0, op};
            4'b0001: return a;
            4'b0010: return b;
            4'b0011: return result;
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: time since reset release decides everything.
    // Frame starts every FRAME cycles, slots every SD cycles.
    int          t_m       = 0;
    int          last_load = -1;
    int          exp_gap   = 0;
    bit          exp_tick  = 1'b0;
    logic [31:0] m_snap    = 32'h0;

    always @(posedge clk) begin : model
        int   d;
        exp_t e;
        if (rst) begin
            t_m       = 0;
            last_load = -1;
            exp_gap   = 0;
            exp_tick  = 1'b0;
            m_snap    = 32'h0;
            exp_q.delete();
        end else begin
            exp_tick = 1'b0;
            if (t_m % FRAME == 0 && !freeze) begin
                m_snap   = pick(sw);
                exp_tick = 1'b1;
                exp_gap  = (last_load >= 0) ? t_m - last_load : 0;
                last_load = t_m;
            end
            if (t_m % SD == 0) begin
                d     = (t_m / SD) % 8;
                e.en  = ~(8'h01 << d);
                e.led = seg_tbl[4'(m_snap >> (4 * d))];
                exp_q.push_back(e);
            end
            t_m++;
        end
    end

    // Monitor: samples just after each edge, pops one entry per lit
    // digit and checks run lengths and spacings.
    int   cyc_n     = 0;
    bit   prev_show = 1'b0;
    int   run_len   = 0;
    int   ff_len    = 0;
    int   last_fall = 0;
    bit   have_fall = 1'b0;
    int   last_tick = 0;
    exp_t cur       = '0;

    always @(posedge clk) begin : monitor
        #1;
        cyc_n++;
        if (rst) begin
            chk("rst_en", 32'(en), 32'hFF);
            chk("rst_led", 32'(led), 32'h7F);
            chk("rst_tick", 32'(frame_tick), 32'h0);
            prev_show = 1'b0;
            run_len   = 0;
            ff_len    = 0;
            have_fall = 1'b0;
        end else begin
            chk("tick", 32'(frame_tick), 32'(exp_tick));
            if (frame_tick) begin
                if (exp_gap > 0)
                    chk("tick_gap", 32'(cyc_n - last_tick), 32'(exp_gap));
                last_tick = cyc_n;
            end
            if (en != 8'hFF) begin
                if (!prev_show) begin
                    chk("blank_len", 32'(ff_len), 32'(BC));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: digit en=%h with no entry",
                                 en);
                    end else begin
                        cur = exp_q.pop_front();
                        n_pop++;
                    end
                    if (have_fall)
                        chk("fall_gap", 32'(cyc_n - last_fall), 32'(SD));
                    last_fall = cyc_n;
                    have_fall = 1'b1;
                    run_len   = 0;
                end
                run_len++;
                chk("digit_en", 32'(en), 32'(cur.en));
                chk("digit_led", 32'(led), 32'(cur.led));
                prev_show = 1'b1;
            end else begin
                chk("blank_led", 32'(led), 32'h7F);
                if (prev_show) begin
                    chk("show_len", 32'(run_len), 32'(SD - BC));
                    ff_len = 0;
                end
                ff_len++;
                prev_show = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3 * FRAME) begin
            errors++;
            $display("FAIL %s: no frame_tick within %0d cycles", tag, n);
        end
    endtask

    initial begin
        // Reset scan of result = 76543210.
        cyc(3);
        rst = 1'b0;
        cyc(FRAME + 4);

        // Opcode source, then an unused select code.
        sw = 4'b0000;
        op = 6'h23;
        a  = 32'hDEADBEEF;
        cyc(FRAME);
        sw    = 4'b1111;
        instr = 32'h89ABCDEF;
        cyc(FRAME);

        // Source switch during digit 3 must not tear the frame.
        sw = 4'b0001;
        a  = 32'hFFFFFFFF;
        b  = 32'h0;
        wait_tick("tear_sync");
        cyc(27);
        sw = 4'b0010;
        cyc(2 * FRAME);

        // Freeze across load points, then release.
        sw = 4'b0001;
        a  = 32'h13579BDF;
        wait_tick("freeze_sync");
        cyc(2);
        freeze = 1'b1;
        a      = 32'h2468ACE0;
        cyc(2 * FRAME);
        freeze = 1'b0;
        cyc(2 * FRAME);

        // Random sources, operands and freeze toggles.
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) != 0)
                sw = 4'($urandom_range(0, 4));
            else
                sw = 4'($urandom_range(0, 15));
            op     = 6'($urandom);
            a      = $urandom;
            b      = $urandom;
            result = $urandom;
            instr  = $urandom;
            freeze = ($urandom_range(0, 3) == 0);
            cyc($urandom_range(3, 100));
        end

        // Reset during digit 5 with freeze held: display restarts at
        // digit 0 from a cleared snapshot.
        freeze = 1'b1;
        begin : find_d5
            int n = 0;
            while (en !== 8'hDF && n < 3 * FRAME) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 3 * FRAME) begin
                errors++;
                $display("FAIL d5_sync: digit 5 not seen in %0d cycles", n);
            end
        end
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(FRAME + 8);
        freeze = 1'b0;
        sw     = 4'b0011;
        result = 32'hA5C3E1F0;
        cyc(2 * FRAME);

        cyc(10);
        chk("sb_drain", 32'(exp_q.size() <= 1), 32'h1);
        chk("pops_seen", 32'(n_pop >= 150), 32'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
